// File: rtl/alu_arbiter_if.sv
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Bundle of the two requester channels, the two response
//                channels and the shared-ALU port used by alu_arbiter.
//                The slave modport is the arbiter's view. The master modport
//                is the environment's view (requesters plus ALU).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_ALUOP_RANGE
`define RV_ALUOP_RANGE 4:0
`endif

interface alu_arbiter_if;

    // Requester 0
    logic                      req0_valid_i;
    logic                      req0_ready_o;
    logic [`RV_XLEN-1:0]       req0_left_i;
    logic [`RV_XLEN-1:0]       req0_right_i;
    logic [`RV_ALUOP_RANGE]    req0_opcode_i;
    logic                      rsp0_valid_o;
    logic                      rsp0_ready_i;

    // Requester 1
    logic                      req1_valid_i;
    logic                      req1_ready_o;
    logic [`RV_XLEN-1:0]       req1_left_i;
    logic [`RV_XLEN-1:0]       req1_right_i;
    logic [`RV_ALUOP_RANGE]    req1_opcode_i;
    logic                      rsp1_valid_o;
    logic                      rsp1_ready_i;

    // Shared ALU
    logic [`RV_XLEN-1:0]       alu_op_left_o;
    logic [`RV_XLEN-1:0]       alu_op_right_o;
    logic [`RV_ALUOP_RANGE]    alu_op_opcode_o;
    logic                      alu_clk_en_o;
    logic [`RV_XLEN-1:0]       alu_op_result_i;

    // Shared response data
    logic [`RV_XLEN-1:0]       rsp_result_o;

    // Arbiter side
    modport slave (
        input  req0_valid_i, req0_left_i, req0_right_i, req0_opcode_i, rsp0_ready_i,
        input  req1_valid_i, req1_left_i, req1_right_i, req1_opcode_i, rsp1_ready_i,
        input  alu_op_result_i,
        output req0_ready_o, rsp0_valid_o,
        output req1_ready_o, rsp1_valid_o,
        output alu_op_left_o, alu_op_right_o, alu_op_opcode_o, alu_clk_en_o,
        output rsp_result_o
    );

    // Environment side: requesters and the ALU
    modport master (
        output req0_valid_i, req0_left_i, req0_right_i, req0_opcode_i, rsp0_ready_i,
        output req1_valid_i, req1_left_i, req1_right_i, req1_opcode_i, rsp1_ready_i,
        output alu_op_result_i,
        input  req0_ready_o, rsp0_valid_o,
        input  req1_ready_o, rsp1_valid_o,
        input  alu_op_left_o, alu_op_right_o, alu_op_opcode_o, alu_clk_en_o,
        input  rsp_result_o
    );

endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester arbiter in front of one shared, registered
//                ALU. A single result slot (EMPTY/FULL plus an owner bit)
//                tracks the one result the ALU register can hold.
//
//                A new operation may issue when the slot is empty. It may
//                also issue when the current owner drains the slot in the
//                same cycle. This gives one operation per cycle when the
//                response side keeps up.
//
//                Optional macro RV_ALU_ARB_RR_EN enables round-robin
//                arbitration. When it is undefined, requester 0 has fixed
//                priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`ifndef RV_ALUOP_RANGE
`define RV_ALUOP_RANGE 4:0
`endif

module alu_arbiter (
    input  wire logic    clk_i,
    input  wire logic    resetb_i,
    alu_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    slot_t  slot_q, slot_d;
    logic   owner_q, owner_d;     // requester that owns the result in the slot

    logic   owner_ready;          // owner consumes its result this cycle
    logic   issue_ok;             // ALU result register is free to be reloaded
    logic   any_valid;
    logic   sel;                  // requester selected by arbitration
    logic   issue;                // an operation transfers this cycle

    // Only the owner's ready matters. The non-owner's ready never affects
    // the grant.
    always_comb begin
        owner_ready = owner_q ? bus.rsp1_ready_i : bus.rsp0_ready_i;
    end

    // Decide whether the slot can accept a new result this cycle.
    always_comb begin
        any_valid = bus.req0_valid_i | bus.req1_valid_i;
        issue_ok  = (slot_q == SLOT_EMPTY) || owner_ready;
        // Holding the issue low while reset is asserted keeps every output
        // at zero, even if a requester presents valid during reset.
        issue     = resetb_i & issue_ok & any_valid;
    end

`ifdef RV_ALU_ARB_RR_EN
    logic prio_q, prio_d;         // requester favoured on a tie

    // Round-robin selection. On a tie, the favoured requester wins.
    always_comb begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
            sel = prio_q;
        end else begin
            sel = ~bus.req0_valid_i;
        end
    end

    // Only a real issue moves the pointer. The loser of the last grant
    // becomes the favoured requester.
    always_comb begin
        prio_d = prio_q;
        if (issue) begin
            prio_d = ~sel;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        sel = ~bus.req0_valid_i;
    end
`endif

    // Slot state and owner registers. Reset discards any pending result.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            slot_q  <= SLOT_EMPTY;
            owner_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            owner_q <= owner_d;
        end
    end

    // Slot next state.
    // An issue always fills the slot for the new owner.
    // When the owner drains the slot with no new issue, the slot empties.
    // Otherwise the slot holds.
    always_comb begin
        slot_d  = slot_q;
        owner_d = owner_q;
        case (slot_q)
            SLOT_EMPTY: begin
                if (issue) begin
                    slot_d  = SLOT_FULL;
                    owner_d = sel;
                end
            end
            SLOT_FULL: begin
                if (issue) begin
                    slot_d  = SLOT_FULL;
                    owner_d = sel;
                end else if (owner_ready) begin
                    slot_d  = SLOT_EMPTY;
                end
            end
            default: begin
                slot_d  = SLOT_EMPTY;
                owner_d = 1'b0;
            end
        endcase
    end

    // Handshake, ALU drive and response outputs.
    // ALU operands are zero whenever nothing issues.
    always_comb begin
        bus.req0_ready_o    = 1'b0;
        bus.req1_ready_o    = 1'b0;
        bus.alu_clk_en_o    = 1'b0;
        bus.alu_op_left_o   = '0;
        bus.alu_op_right_o  = '0;
        bus.alu_op_opcode_o = '0;

        if (issue) begin
            bus.alu_clk_en_o = 1'b1;
            if (sel) begin
                bus.req1_ready_o    = 1'b1;
                bus.alu_op_left_o   = bus.req1_left_i;
                bus.alu_op_right_o  = bus.req1_right_i;
                bus.alu_op_opcode_o = bus.req1_opcode_i;
            end else begin
                bus.req0_ready_o    = 1'b1;
                bus.alu_op_left_o   = bus.req0_left_i;
                bus.alu_op_right_o  = bus.req0_right_i;
                bus.alu_op_opcode_o = bus.req0_opcode_i;
            end
        end

        bus.rsp0_valid_o = (slot_q == SLOT_FULL) && !owner_q;
        bus.rsp1_valid_o = (slot_q == SLOT_FULL) &&  owner_q;
        bus.rsp_result_o = resetb_i ? bus.alu_op_result_i : '0;
    end

endmodule

`default_nettype wire
